// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel front end (line buffer + 3x3 window).
package sobel_pkg;

  // Grey pixel width.
  localparam int PIX_W = 8;

  // Line-buffer address width; also the width of the column and line counters.
  localparam int ADDR_W = 10;

  // Clocks from an input pixel to the matching window and control outputs.
  localparam int PIPE_LAT = 2;

  // Frame lock: outputs stay quiet until the first vsync rising edge.
  typedef enum logic {
    WAIT_SYNC = 1'b0,
    LOCKED    = 1'b1
  } lock_state_t;

endpackage

// File: rtl/line_shift_ram_8bit.sv
// Two-line shift buffer. Each accepted pixel is written at the current
// column, the previous line's pixel at that column moves down one line,
// and both older pixels appear on the taps one clock later.
module line_shift_ram_8bit
  import sobel_pkg::*;
#(
  parameter int IMG_HDISP = 640
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clken,
  input  logic             href,
  input  logic [PIX_W-1:0] shiftin,
  output logic [PIX_W-1:0] taps0x,
  output logic [PIX_W-1:0] taps1x
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_HDISP - 1);

  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  mem0 [DEPTH];
  logic [PIX_W-1:0]  mem1 [DEPTH];
  logic              shift_en;

  // A pixel only counts while the line is valid.
  assign shift_en = clken & href;

  // Column address: restarts each line, wraps after one full line length.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (!href) begin
      addr <= '0;
    end else if (clken) begin
      addr <= (addr == LAST_ADDR) ? '0 : addr + 10'd1;
    end
  end

  // Storage: new pixel into line 0, old line 0 pixel into line 1.
  always_ff @(posedge clock) begin
    if (shift_en) begin
      mem0[addr] <= shiftin;
      mem1[addr] <= mem0[addr];
    end
  end

  // Taps: the two older pixels at this column, registered once.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      taps0x <= '0;
      taps1x <= '0;
    end else if (shift_en) begin
      taps0x <= mem0[addr];
      taps1x <= mem1[addr];
    end
  end

endmodule

// File: rtl/matrix_3x3_8bit.sv
// 3x3 window generator: aligns the current row with the two buffered rows,
// shifts them into a window, re-times vsync/href/clken and flags complete
// windows.
//
// Pixel transfer: per_frame_clken qualified by per_frame_href carries one
// pixel per asserted cycle; there is no back-pressure, so every strobe is
// accepted. On the output side matrix_frame_clken marks each cycle where
// the window has just advanced by one pixel, two clocks after the input.
module matrix_3x3_8bit
  import sobel_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [PIX_W-1:0] per_img_y,
  output logic             matrix_frame_vsync,
  output logic             matrix_frame_href,
  output logic             matrix_frame_clken,
  output logic             matrix_valid,
  output logic [PIX_W-1:0] matrix_p11,
  output logic [PIX_W-1:0] matrix_p12,
  output logic [PIX_W-1:0] matrix_p13,
  output logic [PIX_W-1:0] matrix_p21,
  output logic [PIX_W-1:0] matrix_p22,
  output logic [PIX_W-1:0] matrix_p23,
  output logic [PIX_W-1:0] matrix_p31,
  output logic [PIX_W-1:0] matrix_p32,
  output logic [PIX_W-1:0] matrix_p33
);

  localparam logic [ADDR_W-1:0] LINE_MAX = ADDR_W'(IMG_VDISP);
  localparam logic [ADDR_W-1:0] COL_MAX  = '1;

  lock_state_t state_q, state_d;
  logic        locked;

  logic [PIPE_LAT-1:0] vsync_pipe;
  logic                href_d1;
  logic                clken_d1;
  logic                pix_en;
  logic                vsync_rise;
  logic                href_fall;

  logic [ADDR_W-1:0] col_cnt;
  logic [ADDR_W-1:0] line_cnt;

  logic [PIX_W-1:0] taps0x, taps1x;
  logic [PIX_W-1:0] row1, row2, row3;
  logic             line_ge1_d1, line_ge2_d1, valid_d1;

  assign pix_en     = per_frame_clken & per_frame_href;
  assign vsync_rise = per_frame_vsync & ~vsync_pipe[0];
  assign href_fall  = ~per_frame_href & href_d1;

  line_shift_ram_8bit #(
    .IMG_HDISP (IMG_HDISP)
  ) u_line_buf (
    .clock   (clock),
    .rst_n   (rst_n),
    .clken   (per_frame_clken),
    .href    (per_frame_href),
    .shiftin (per_img_y),
    .taps0x  (taps0x),
    .taps1x  (taps1x)
  );

  // Frame lock state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_SYNC;
    else        state_q <= state_d;
  end

  // Next state: lock on the first vsync rising edge, then stay locked.
  always_comb begin
    state_d = state_q;
    locked  = 1'b0;
    case (state_q)
      WAIT_SYNC: if (vsync_rise) state_d = LOCKED;
      LOCKED:    locked = 1'b1;
      default:   state_d = WAIT_SYNC;
    endcase
  end

  // Column counter: cleared outside href, counts strobes, saturates.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
    end else if (!per_frame_href) begin
      col_cnt <= '0;
    end else if (per_frame_clken && col_cnt != COL_MAX) begin
      col_cnt <= col_cnt + 10'd1;
    end
  end

  // Line counter: vsync clear has priority over an href falling edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt <= '0;
    end else if (vsync_rise) begin
      line_cnt <= '0;
    end else if (href_fall && line_cnt < LINE_MAX) begin
      line_cnt <= line_cnt + 10'd1;
    end
  end

  // Stage 1: delay controls, register current row, capture counter flags.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_pipe  <= '0;
      href_d1     <= 1'b0;
      clken_d1    <= 1'b0;
      row3        <= '0;
      line_ge1_d1 <= 1'b0;
      line_ge2_d1 <= 1'b0;
      valid_d1    <= 1'b0;
    end else begin
      vsync_pipe  <= {vsync_pipe[PIPE_LAT-2:0], per_frame_vsync};
      href_d1     <= per_frame_href;
      clken_d1    <= pix_en;
      row3        <= per_img_y;
      line_ge1_d1 <= (line_cnt >= 10'd1);
      line_ge2_d1 <= (line_cnt >= 10'd2);
      valid_d1    <= pix_en && (line_cnt >= 10'd2) && (col_cnt >= 10'd3);
    end
  end

  // Rows above the frame's first lines are zero-filled instead of stale.
  assign row1 = line_ge2_d1 ? taps1x : '0;
  assign row2 = line_ge1_d1 ? taps0x : '0;

  // Stage 2: shift the window on each delayed strobe while locked.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
      matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
      matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
    end else if (clken_d1 && locked) begin
      matrix_p11 <= matrix_p12; matrix_p12 <= matrix_p13; matrix_p13 <= row1;
      matrix_p21 <= matrix_p22; matrix_p22 <= matrix_p23; matrix_p23 <= row2;
      matrix_p31 <= matrix_p32; matrix_p32 <= matrix_p33; matrix_p33 <= row3;
    end
  end

  // Stage 2 controls: gated off until the frame lock is established.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      matrix_frame_href  <= 1'b0;
      matrix_frame_clken <= 1'b0;
      matrix_valid       <= 1'b0;
    end else begin
      matrix_frame_href  <= href_d1 & locked;
      matrix_frame_clken <= clken_d1 & locked;
      matrix_valid       <= valid_d1 & locked;
    end
  end

  assign matrix_frame_vsync = vsync_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_matrix_3x3_8bit.sv
// Directed bench for matrix_3x3_8bit on an 8-pixel-wide, 4-line frame.
module tb_matrix_3x3_8bit;
  import sobel_pkg::*;

  localparam int IMG_H = 8;
  localparam int IMG_V = 4;

  logic       clock;
  logic       rst_n;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic [7:0] per_img_y;
  logic       matrix_frame_vsync;
  logic       matrix_frame_href;
  logic       matrix_frame_clken;
  logic       matrix_valid;
  logic [7:0] matrix_p11, matrix_p12, matrix_p13;
  logic [7:0] matrix_p21, matrix_p22, matrix_p23;
  logic [7:0] matrix_p31, matrix_p32, matrix_p33;

  int n_cmp = 0;
  int n_bad = 0;
  int out_act_cnt = 0;

  // Windows ({p11..p33}) and valid flags captured on each output strobe.
  logic [71:0] win_q[$];
  logic        val_q[$];

  matrix_3x3_8bit #(
    .IMG_HDISP (IMG_H),
    .IMG_VDISP (IMG_V)
  ) dut (
    .clock              (clock),
    .rst_n              (rst_n),
    .per_frame_vsync    (per_frame_vsync),
    .per_frame_href     (per_frame_href),
    .per_frame_clken    (per_frame_clken),
    .per_img_y          (per_img_y),
    .matrix_frame_vsync (matrix_frame_vsync),
    .matrix_frame_href  (matrix_frame_href),
    .matrix_frame_clken (matrix_frame_clken),
    .matrix_valid       (matrix_valid),
    .matrix_p11         (matrix_p11),
    .matrix_p12         (matrix_p12),
    .matrix_p13         (matrix_p13),
    .matrix_p21         (matrix_p21),
    .matrix_p22         (matrix_p22),
    .matrix_p23         (matrix_p23),
    .matrix_p31         (matrix_p31),
    .matrix_p32         (matrix_p32),
    .matrix_p33         (matrix_p33)
  );

  // Clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (matrix_frame_href || matrix_frame_clken || matrix_valid) out_act_cnt++;
    if (matrix_frame_clken) begin
      win_q.push_back({matrix_p11, matrix_p12, matrix_p13,
                       matrix_p21, matrix_p22, matrix_p23,
                       matrix_p31, matrix_p32, matrix_p33});
      val_q.push_back(matrix_valid);
    end
  endtask

  task automatic send_vsync();
    per_frame_vsync = 1'b1;
    repeat (2) tick();
    per_frame_vsync = 1'b0;
    repeat (2) tick();
  endtask

  // One line of IMG_H pixels (ramp 16*line+col, or all 0xFF), then blanking.
  task automatic send_line(input int line, input bit gapped, input bit all_ff);
    win_q.delete();
    val_q.delete();
    per_frame_href = 1'b1;
    for (int c = 0; c < IMG_H; c++) begin
      per_frame_clken = 1'b1;
      per_img_y = all_ff ? 8'hFF : 8'(16 * line + c);
      tick();
      if (gapped) begin
        per_frame_clken = 1'b0;
        per_img_y = 8'h5A;
        tick();
      end
    end
    per_frame_clken = 1'b0;
    per_frame_href = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [107:0] all_out;
    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href = 1'b0;
    per_frame_clken = 1'b0;
    per_img_y = 8'h00;
    repeat (3) tick();
    all_out = {matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, matrix_valid,
               matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
               matrix_p23, matrix_p31, matrix_p32, matrix_p33, 32'h0};
    n_cmp++;
    if (all_out !== 108'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    n_cmp++;
    if (dut.state_q !== WAIT_SYNC) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want %0d", dut.state_q, WAIT_SYNC);
    end
    n_cmp++;
    if ({dut.col_cnt, dut.line_cnt} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_counters: got col %0d line %0d want 0 0", dut.col_cnt, dut.line_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lock();
    out_act_cnt = 0;
    send_line(0, 1'b0, 1'b0);
    n_cmp++;
    if (out_act_cnt !== 0) begin
      n_bad++;
      $display("FAIL prelock_quiet: got %0d active cycles want 0", out_act_cnt);
    end
    per_frame_vsync = 1'b1;
    tick();
    n_cmp++;
    if (matrix_frame_vsync !== 1'b0) begin
      n_bad++;
      $display("FAIL vsync_delay1: got %b want 0", matrix_frame_vsync);
    end
    tick();
    n_cmp++;
    if (matrix_frame_vsync !== 1'b1) begin
      n_bad++;
      $display("FAIL vsync_delay2: got %b want 1", matrix_frame_vsync);
    end
    n_cmp++;
    if (dut.state_q !== LOCKED) begin
      n_bad++;
      $display("FAIL lock_state: got %0d want %0d", dut.state_q, LOCKED);
    end
    per_frame_vsync = 1'b0;
    repeat (2) tick();
  endtask

  // Lines 2 and 3 of the ramp frame, continuous or 50% gapped clken.
  task automatic check_ramp_line2(input string tag);
    logic [71:0] exp_w;
    n_cmp++;
    if (win_q.size() !== 8) begin
      n_bad++;
      $display("FAIL %s_l2_count: got %0d strobes want 8", tag, win_q.size());
    end
    if (win_q.size() == 8) begin
      exp_w = {8'h00, 8'h00, 8'h00, 8'h06, 8'h07, 8'h10, 8'h16, 8'h17, 8'h20};
      n_cmp++;
      if (win_q[0] !== exp_w) begin
        n_bad++;
        $display("FAIL %s_l2_win0: got %h want %h", tag, win_q[0], exp_w);
      end
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (val_q[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_l2_valid%0d: got %b want 0", tag, i, val_q[i]);
        end
      end
      exp_w = {8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
      n_cmp++;
      if (win_q[3] !== exp_w || val_q[3] !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_l2_win3: got %h valid %b want %h valid 1", tag, win_q[3], val_q[3], exp_w);
      end
    end
  endtask

  task automatic test_ramp();
    logic [71:0] exp_w;
    send_vsync();
    send_line(0, 1'b0, 1'b0);
    send_line(1, 1'b0, 1'b0);
    send_line(2, 1'b0, 1'b0);
    check_ramp_line2("ramp");
    send_line(3, 1'b0, 1'b0);
    exp_w = {8'h15, 8'h16, 8'h17, 8'h25, 8'h26, 8'h27, 8'h35, 8'h36, 8'h37};
    n_cmp++;
    if (win_q.size() != 8 || win_q[7] !== exp_w || val_q[7] !== 1'b1) begin
      n_bad++;
      $display("FAIL ramp_l3_win7: got %h (n=%0d) want %h valid 1",
               win_q.size() == 8 ? win_q[7] : 72'h0, win_q.size(), exp_w);
    end
  endtask

  task automatic test_top_mask();
    int bad;
    send_vsync();
    for (int l = 0; l < IMG_V; l++) send_line(l, 1'b0, 1'b1);
    send_vsync();
    send_line(0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < win_q.size(); i++) begin
      if (win_q[i][55:48] !== 8'h00 || win_q[i][31:24] !== 8'h00) bad++;
      if (i >= 2 && win_q[i][71:24] !== 48'h0) bad++;
      if (val_q[i] !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0 || win_q.size() !== 8) begin
      n_bad++;
      $display("FAIL mask_line0: got %0d bad windows of %0d want 0 of 8", bad, win_q.size());
    end
    send_line(1, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < win_q.size(); i++) begin
      if (win_q[i][71:48] !== 24'h0) bad++;
      if (val_q[i] !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0 || win_q.size() !== 8) begin
      n_bad++;
      $display("FAIL mask_line1: got %0d bad windows of %0d want 0 of 8", bad, win_q.size());
    end
  endtask

  task automatic test_latency();
    per_frame_href = 1'b1;
    per_frame_clken = 1'b0;
    tick();
    per_frame_clken = 1'b1;
    per_img_y = 8'hA5;
    tick();
    per_frame_clken = 1'b0;
    per_img_y = 8'h00;
    n_cmp++;
    if (matrix_frame_clken !== 1'b0) begin
      n_bad++;
      $display("FAIL lat_clk1: got %b want 0", matrix_frame_clken);
    end
    tick();
    n_cmp++;
    if (matrix_frame_clken !== 1'b1 || matrix_p33 !== 8'hA5) begin
      n_bad++;
      $display("FAIL lat_clk2: got clken %b p33 %h want 1 a5", matrix_frame_clken, matrix_p33);
    end
    tick();
    n_cmp++;
    if (matrix_frame_clken !== 1'b0) begin
      n_bad++;
      $display("FAIL lat_clk3: got %b want 0", matrix_frame_clken);
    end
    per_frame_href = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_gapped();
    send_vsync();
    send_line(0, 1'b1, 1'b0);
    send_line(1, 1'b1, 1'b0);
    send_line(2, 1'b1, 1'b0);
    check_ramp_line2("gap");
  endtask

  task automatic test_reset_mid_frame();
    logic [107:0] all_out;
    logic [71:0]  win;
    int bad;
    send_vsync();
    send_line(0, 1'b0, 1'b0);
    send_line(1, 1'b0, 1'b0);
    per_frame_href = 1'b1;
    per_frame_clken = 1'b1;
    for (int c = 0; c < 4; c++) begin
      per_img_y = 8'(32 + c);
      tick();
    end
    rst_n = 1'b0;
    #1;
    all_out = {matrix_frame_vsync, matrix_frame_href, matrix_frame_clken, matrix_valid,
               matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
               matrix_p23, matrix_p31, matrix_p32, matrix_p33, 32'h0};
    n_cmp++;
    if (all_out !== 108'h0) begin
      n_bad++;
      $display("FAIL midrst_async: got %h want 0", all_out);
    end
    for (int c = 4; c < 7; c++) begin
      per_img_y = 8'(32 + c);
      tick();
    end
    rst_n = 1'b1;
    out_act_cnt = 0;
    per_img_y = 8'h27;
    tick();
    per_frame_clken = 1'b0;
    per_frame_href = 1'b0;
    repeat (3) tick();
    send_line(3, 1'b0, 1'b0);
    win = {matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
           matrix_p23, matrix_p31, matrix_p32, matrix_p33};
    n_cmp++;
    if (out_act_cnt !== 0 || win !== 72'h0) begin
      n_bad++;
      $display("FAIL midrst_quiet: got %0d active cycles window %h want 0 0", out_act_cnt, win);
    end
    send_vsync();
    send_line(0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < val_q.size(); i++) if (val_q[i] !== 1'b0) bad++;
    n_cmp++;
    if (bad !== 0 || win_q.size() !== 8) begin
      n_bad++;
      $display("FAIL midrst_resume: got %0d valid of %0d strobes want 0 of 8", bad, win_q.size());
    end
  endtask

  task automatic test_saturation();
    int bad;
    send_vsync();
    send_line(0, 1'b0, 1'b0);
    send_line(1, 1'b0, 1'b0);
    win_q.delete();
    val_q.delete();
    per_frame_href = 1'b1;
    per_frame_clken = 1'b1;
    for (int c = 0; c < 1030; c++) begin
      per_img_y = 8'(c);
      tick();
    end
    n_cmp++;
    if (dut.col_cnt !== 10'd1023) begin
      n_bad++;
      $display("FAIL col_sat: got %0d want 1023", dut.col_cnt);
    end
    per_frame_clken = 1'b0;
    per_frame_href = 1'b0;
    repeat (3) tick();
    bad = 0;
    for (int i = 3; i < val_q.size(); i++) if (val_q[i] !== 1'b1) bad++;
    n_cmp++;
    if (bad !== 0 || val_q.size() !== 1030) begin
      n_bad++;
      $display("FAIL sat_valid: got %0d low of %0d strobes want 0 of 1030", bad, val_q.size());
    end
    send_line(3, 1'b0, 1'b0);
    send_line(4, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0);
    n_cmp++;
    if (dut.line_cnt !== 10'(IMG_V)) begin
      n_bad++;
      $display("FAIL line_sat: got %0d want %0d", dut.line_cnt, IMG_V);
    end
  endtask

  task automatic test_vsync_vs_href_fall();
    per_frame_href = 1'b1;
    repeat (2) tick();
    per_frame_href = 1'b0;
    per_frame_vsync = 1'b1;
    tick();
    n_cmp++;
    if (dut.line_cnt !== 10'd0) begin
      n_bad++;
      $display("FAIL vsync_priority: got %0d want 0", dut.line_cnt);
    end
    per_frame_vsync = 1'b0;
    repeat (2) tick();
  endtask

  // Sequence of scenarios, then the summary.
  initial begin
    test_reset();
    test_lock();
    test_ramp();
    test_top_mask();
    test_latency();
    test_gapped();
    test_reset_mid_frame();
    test_saturation();
    test_vsync_vs_href_fall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_3x3_8bit.md
# matrix_3x3_8bit

Reader-side companion to the Sobel line buffer. It takes the raw 8-bit grey pixel stream, passes it through `line_shift_ram_8bit` and collects the current row plus the two stored rows into an aligned 3×3 window. It sits between the grey-conversion stage and the Sobel gradient/threshold logic. It also re-times the frame control signals (vsync, href, clken) to match the window, and flags when a window is complete.

## Interface
Parameters:
- `IMG_HDISP`, default 640: active pixels per line. The legal range is 3..1024, bounded by the 10-bit line-buffer address.
- `IMG_VDISP`, default 480: active lines per frame, 3..1023. Used only for the line counter's saturation check.

Ports:
- `clock`, in, 1: pixel clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `per_frame_vsync`, in, 1: frame sync, active high.
- `per_frame_href`, in, 1: line valid, active high.
- `per_frame_clken`, in, 1: pixel strobe, qualified by href.
- `per_img_y`, in, 8: grey pixel.
- `matrix_frame_vsync`, out, 1: vsync delayed by 2 clocks.
- `matrix_frame_href`, out, 1: href delayed by 2 clocks.
- `matrix_frame_clken`, out, 1: clken delayed by 2 clocks.
- `matrix_valid`, out, 1: the window holds 9 real pixels of the current frame.
- `matrix_p11`, `matrix_p12`, `matrix_p13`, out, 8 each: top row (2 lines ago), left to right.
- `matrix_p21`, `matrix_p22`, `matrix_p23`, out, 8 each: middle row (1 line ago).
- `matrix_p31`, `matrix_p32`, `matrix_p33`, out, 8 each: current row; `p33` is the newest pixel.

## Operation
- Line buffer:
  - `line_shift_ram_8bit` is driven with `clock`, `per_frame_clken`, `per_frame_href` and `shiftin = per_img_y`.
  - `taps0x` gives the previous line and `taps1x` the line before it. Both are valid 1 clock after the `clken` that addressed them.
- Row alignment: `per_img_y` is registered once as `row3`, so the current-row pixel lines up with `taps0x` and `taps1x`.
- Window shift, on `clken_d1`:
  - `p11<=p12`, `p12<=p13`, `p13<=row1`.
  - `p21<=p22`, `p22<=p23`, `p23<=row2`.
  - `p31<=p32`, `p32<=p33`, `p33<=row3`.
  - When `clken_d1` is low, all nine window registers hold.
- Row masking:
  - `row1` is `taps1x` when `line_cnt>=2`, else 0.
  - `row2` is `taps0x` when `line_cnt>=1`, else 0.
  - Stale data from the previous frame therefore never reaches the window; the top rows are zero-filled.
- Column counter `col_cnt`, 10 bits:
  - Cleared while `per_frame_href` is low.
  - Increments on each `clken` within href.
  - Saturates at 1023.
- Line counter `line_cnt`, 10 bits:
  - Cleared on the vsync rising edge.
  - Increments on each href falling edge.
  - Saturates at `IMG_VDISP`.
- `matrix_valid` asserts together with `matrix_frame_clken` when `line_cnt>=2` and `col_cnt>=3`, with both counters sampled at the pixel's input cycle and pipelined with it. Otherwise it is low.
- Frame lock, two states:
  - WAIT_SYNC: after reset, `matrix_frame_href`, `matrix_frame_clken` and `matrix_valid` are forced low. The block moves to LOCKED on the first vsync rising edge.
  - LOCKED: outputs pass through.
  - Partial frames after reset are therefore never emitted.
- Simultaneous events:
  - If a vsync rising edge and an href falling edge occur in the same cycle, the vsync clear wins and `line_cnt=0`.
  - `clken` while href is low is ignored: no counter or shift update. The line buffer ignores it natively.

## Timing
- Reset values: every output register is 0, the FSM is WAIT_SYNC, and both counters are 0. Reset is asynchronous assert and synchronous-release safe.
- Latency: 2 clocks from input to output on all control outputs.
  - Clock 1: RAM read and `row3` register.
  - Clock 2: window shift.
- `p33` equals `per_img_y` from 2 clocks earlier whenever `matrix_frame_clken=1`.
- No back-pressure: one pixel per `clken`, and continuous clken is supported.
- Horizontal blanking: at least 2 clocks of `href=0` between lines, so the delayed signals drain.
- Reset mid-line discards the window. Output resumes at the next frame only.

## Structure
- Package `sobel_pkg` holds:
  - the pixel width constant (8);
  - the address width (10);
  - the pipeline latency (2);
  - the FSM state enum `{WAIT_SYNC, LOCKED}`.
- One sub-module: `line_shift_ram_8bit`, used unchanged.
- Delay taps, counters, window registers and FSM live in the top level.

## Test plan
- **Ramp, 8×4 frame.** Stimulus: `IMG_HDISP=8`, pixel = 16·line + col. Required response, on the 4th `clken` of line 2: window rows are `{0x01,0x02,0x03}`, `{0x11,0x12,0x13}`, `{0x21,0x22,0x23}`, and `matrix_valid=1`.
- **Top-edge masking.** Stimulus: line 0 of a frame that follows a frame of all 0xFF. Required response: `p1x=p2x=0`, and `matrix_valid=0` for all of line 0 and line 1.
- **Latency.** Stimulus: a single `clken` pulse with `y=0xA5`. Required response: `matrix_frame_clken` high exactly 2 clocks later, with `p33=0xA5`.
- **Gapped clken.** Stimulus: clken at 50% duty within href. Required response: the window advances only on strobes, with the same contents as the ramp case.
- **Reset mid-frame.** Stimulus: `rst_n` low for 3 clocks in line 2. Required response: all outputs 0 and href/clken low until the next vsync rising edge; the first line of the following frame then has `matrix_valid=0`.
- **Saturation.** Stimulus: 1030 `clken` in a single href. Required response: `col_cnt` stays at 1023 with no wrap, and `matrix_valid` stays high.
